// File: rtl/mul_arb_seq.sv
// mul_arb_seq: round-robin shared iterative posit mantissa multiplier with carry normalisation
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   reqX_valid/ready/a/b     two requesters, packed operands {is_zero,is_inf,sign,k[N-1:0],mant[N-1:0]}
//   out_valid/ready          result handshake
//   out_tag                  requester ID of the result
//   out_is_zero/is_inf       special result flags
//   out_sign/k/mant          result sign, scale, mantissa (hidden bit at [N-1])
//   busy                     high whenever not IDLE
module mul_arb_seq #(
  parameter int N = 8,
  localparam int W = 2*N+3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_tag,
  output logic         out_is_zero,
  output logic         out_is_inf,
  output logic         out_sign,
  output logic [N-1:0] out_k,
  output logic [N-1:0] out_mant,
  output logic         busy
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, tag_q, tag_d;
  logic [2*N:0] a_q, a_d, b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d, acc_adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_tag_q, out_tag_d, out_is_zero_q, out_is_zero_d, out_is_inf_q, out_is_inf_d;
  logic out_sign_q, out_sign_d;
  logic [N-1:0] out_k_q, out_k_d, out_mant_q, out_mant_d;
  logic idle, gnt0, gnt1, sel_zero, sel_inf;
  logic [W-1:0] sel_a, sel_b;
  // rr_q=0 favours req0; a lone requester always wins
  assign idle = state_q == IDLE;
  assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1 = req1_valid & (~req0_valid | rr_q);
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign sel_a = gnt1 ? req1_a : req0_a;
  assign sel_b = gnt1 ? req1_b : req0_b;
  assign sel_inf = sel_a[2*N+1] | sel_b[2*N+1];
  assign sel_zero = sel_a[2*N+2] | sel_b[2*N+2];
  // product of two 1.f mantissas is in [1,4); a set top bit means one extra integer bit
  assign acc_adj = acc_q[2*N-1] ? acc_q >> 1 : acc_q;
  assign out_valid = state_q == DONE;
  assign busy = ~idle;
  assign out_tag = out_tag_q;
  assign out_is_zero = out_is_zero_q;
  assign out_is_inf = out_is_inf_q;
  assign out_sign = out_sign_q;
  assign out_k = out_k_q;
  assign out_mant = out_mant_q;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    tag_d = tag_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_tag_d = out_tag_q;
    out_is_zero_d = out_is_zero_q;
    out_is_inf_d = out_is_inf_q;
    out_sign_d = out_sign_q;
    out_k_d = out_k_q;
    out_mant_d = out_mant_q;
    case (state_q)
      IDLE: if (gnt0 | gnt1) begin
        tag_d = gnt1;
        rr_d = gnt0;
        a_d = sel_a[2*N:0];
        b_d = sel_b[2*N:0];
        acc_d = '0;
        cnt_d = '0;
        state_d = MUL;
        if (sel_inf | sel_zero) begin
          out_tag_d = gnt1;
          out_is_inf_d = sel_inf;
          out_is_zero_d = ~sel_inf;
          out_sign_d = 1'b0;
          out_k_d = '0;
          out_mant_d = '0;
          state_d = DONE;
        end
      end
      MUL: begin
        acc_d = acc_q + (b_q[cnt_q] ? ({{N{1'b0}}, a_q[N-1:0]} << cnt_q) : '0);
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N-1)) ? NORM : MUL;
      end
      NORM: begin
        acc_d = acc_adj;
        out_tag_d = tag_q;
        out_is_zero_d = 1'b0;
        out_is_inf_d = 1'b0;
        out_sign_d = a_q[2*N] ^ b_q[2*N];
        out_k_d = a_q[2*N-1:N] + b_q[2*N-1:N] + N'(acc_q[2*N-1]);
        out_mant_d = acc_adj[2*N-2:N-1];
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      tag_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out_tag_q <= 1'b0;
      out_is_zero_q <= 1'b0;
      out_is_inf_q <= 1'b0;
      out_sign_q <= 1'b0;
      out_k_q <= '0;
      out_mant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      tag_q <= tag_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_tag_q <= out_tag_d;
      out_is_zero_q <= out_is_zero_d;
      out_is_inf_q <= out_is_inf_d;
      out_sign_q <= out_sign_d;
      out_k_q <= out_k_d;
      out_mant_q <= out_mant_d;
    end
endmodule
